// File: rtl/cla_2_pkg.sv
// Shared constants for the 2-bit registered carry-lookahead block.
// The optional carry-out port is controlled by the macro CLA_2_COUT_EN.
package cla_2_pkg;

  localparam int CLA_W = 2;

  localparam logic [CLA_W-1:0] S_RST     = '0;
  localparam logic             G_RST     = 1'b0;
  localparam logic             P_RST     = 1'b0;
  localparam logic             COUT_RST  = 1'b0;
  localparam logic             VALID_RST = 1'b0;

endpackage : cla_2_pkg

// File: rtl/cla_2_gp.sv
// Single-bit generate/propagate cell used once per operand bit.
module cla_2_gp (
  input  logic a_i,
  input  logic b_i,
  output logic g_i,
  output logic p_i
);

  assign g_i = a_i & b_i;
  assign p_i = a_i ^ b_i;

endmodule : cla_2_gp

// File: rtl/cla_2.sv
// 2-bit carry-lookahead adder with registered sum, group G/P and valid flag.
// Defining CLA_2_COUT_EN adds a registered carry-out port c_out.
module cla_2
  import cla_2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CLA_W-1:0] a,
  input  logic [CLA_W-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [CLA_W-1:0] s,
  output logic             g_out,
  output logic             p_out,
`ifdef CLA_2_COUT_EN
  output logic             c_out,
`endif
  output logic             out_valid
);

  logic [CLA_W-1:0] g;
  logic [CLA_W-1:0] p;

  genvar gi;
  generate
    for (gi = 0; gi < CLA_W; gi++) begin : g_bit
      cla_2_gp u_gp (
        .a_i (a[gi]),
        .b_i (b[gi]),
        .g_i (g[gi]),
        .p_i (p[gi])
      );
    end
  endgenerate

  // Lookahead: c1 comes straight from bit-0 G/P, group terms ignore c_in.
  logic             c1;
  logic [CLA_W-1:0] sum_c;
  logic             grp_g_c;
  logic             grp_p_c;

  assign c1      = g[0] | (p[0] & c_in);
  assign sum_c   = {p[1] ^ c1, p[0] ^ c_in};
  assign grp_g_c = g[1] | (p[1] & g[0]);
  assign grp_p_c = p[1] & p[0];

  logic [CLA_W-1:0] s_q, s_d;
  logic             g_q, g_d;
  logic             p_q, p_d;
  logic             valid_q, valid_d;

  always_comb begin
    s_d     = s_q;
    g_d     = g_q;
    p_d     = p_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d = sum_c;
      g_d = grp_g_c;
      p_d = grp_p_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= S_RST;
      g_q     <= G_RST;
      p_q     <= P_RST;
      valid_q <= VALID_RST;
    end else begin
      s_q     <= s_d;
      g_q     <= g_d;
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign g_out     = g_q;
  assign p_out     = p_q;
  assign out_valid = valid_q;

`ifdef CLA_2_COUT_EN
  logic cout_q, cout_d;

  always_comb begin
    cout_d = cout_q;
    if (in_valid) begin
      cout_d = grp_g_c | (grp_p_c & c_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cout_q <= COUT_RST;
    end else begin
      cout_q <= cout_d;
    end
  end

  assign c_out = cout_q;
`endif

endmodule : cla_2

// File: tb/tb_cla_2.sv
// Self-checking bench for cla_2: directed vectors, async reset, hold,
// exhaustive back-to-back sweep and randomized traffic vs. an arithmetic model.
module tb_cla_2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic       c_in = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] s;
  logic       g_out;
  logic       p_out;
  logic       out_valid;
`ifdef CLA_2_COUT_EN
  logic       c_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // expected output state, maintained by the model
  logic [1:0] exp_s = 2'b00;
  logic       exp_g = 1'b0;
  logic       exp_p = 1'b0;
  logic       exp_co = 1'b0;
  logic       exp_v = 1'b0;

  cla_2 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .s         (s),
    .g_out     (g_out),
    .p_out     (p_out),
`ifdef CLA_2_COUT_EN
    .c_out     (c_out),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic [1:0] s;
    logic       g;
    logic       p;
    logic       co;
  } vec_t;

  // Arithmetic reference: group generate means a+b alone overflows,
  // group propagate means a+b sits exactly at the wrap point (3).
  task automatic model(input logic [1:0] ma, input logic [1:0] mb, input logic mc);
    int tot;
    tot    = int'(ma) + int'(mb) + int'(mc);
    exp_s  = 2'(tot % 4);
    exp_g  = (int'(ma) + int'(mb)) >= 4;
    exp_p  = (int'(ma) + int'(mb)) == 3;
    exp_co = tot >= 4;
  endtask

  task automatic chk1(input string name, input logic [1:0] got, input logic [1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk1({tag, ".s"}, s, exp_s);
    chk1({tag, ".g_out"}, {1'b0, g_out}, {1'b0, exp_g});
    chk1({tag, ".p_out"}, {1'b0, p_out}, {1'b0, exp_p});
    chk1({tag, ".out_valid"}, {1'b0, out_valid}, {1'b0, exp_v});
`ifdef CLA_2_COUT_EN
    chk1({tag, ".c_out"}, {1'b0, c_out}, {1'b0, exp_co});
`endif
  endtask

  // drive on negedge, sample 1 time unit after the next rising edge
  task automatic apply(input logic [1:0] ta, input logic [1:0] tb, input logic tc,
                       input logic tv);
    @(negedge clk);
    a = ta; b = tb; c_in = tc; in_valid = tv;
    @(posedge clk);
    #1;
    if (tv) model(ta, tb, tc);
    exp_v = tv;
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{a: 2'b10, b: 2'b11, cin: 1'b0, s: 2'b01, g: 1'b1, p: 1'b0, co: 1'b1};
    vecs[1] = '{a: 2'b01, b: 2'b01, cin: 1'b0, s: 2'b10, g: 1'b0, p: 1'b0, co: 1'b0};
    vecs[2] = '{a: 2'b01, b: 2'b10, cin: 1'b1, s: 2'b00, g: 1'b0, p: 1'b1, co: 1'b1};

    // reset state, without and with clock edges
    #3;
    check_all("reset_noclk");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_clk");
    @(negedge clk);
    rst = 1'b0;

    // directed table with constant expectations
    for (int i = 0; i < 3; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      chk1($sformatf("vec%0d.s", i), s, vecs[i].s);
      chk1($sformatf("vec%0d.g_out", i), {1'b0, g_out}, {1'b0, vecs[i].g});
      chk1($sformatf("vec%0d.p_out", i), {1'b0, p_out}, {1'b0, vecs[i].p});
      chk1($sformatf("vec%0d.out_valid", i), {1'b0, out_valid}, 2'b01);
`ifdef CLA_2_COUT_EN
      chk1($sformatf("vec%0d.c_out", i), {1'b0, c_out}, {1'b0, vecs[i].co});
`endif
      $display("vec%0d a=%b b=%b c_in=%b -> s=%b g=%b p=%b v=%b",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, s, g_out, p_out, out_valid);
    end

    // hold: in_valid low with different operands
    apply(2'b11, 2'b11, 1'b1, 1'b0);
    chk1("hold.s", s, 2'b00);
    chk1("hold.p_out", {1'b0, p_out}, 2'b01);
    check_all("hold");
    $display("hold a=11 b=11 in_valid=0 -> s=%b g=%b p=%b v=%b", s, g_out, p_out, out_valid);

    // async reset between edges with nonzero outputs
    apply(2'b01, 2'b10, 1'b0, 1'b1);
    check_all("pre_rst");
    @(negedge clk);
    a = 2'b11; b = 2'b10; c_in = 1'b1; in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_s = 2'b00; exp_g = 1'b0; exp_p = 1'b0; exp_co = 1'b0; exp_v = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    apply(2'b11, 2'b10, 1'b1, 1'b1);
    check_all("post_rst");
    $display("async reset then a=11 b=10 c_in=1 -> s=%b g=%b p=%b v=%b", s, g_out, p_out, out_valid);

    // exhaustive back-to-back sweep
    for (int k = 0; k < 32; k++) begin
      logic [4:0] idx;
      idx = 5'(k);
      apply(idx[4:3], idx[2:1], idx[0], 1'b1);
      check_all($sformatf("sweep%0d", k));
      $display("sweep a=%b b=%b c_in=%b -> s=%b g=%b p=%b v=%b",
               idx[4:3], idx[2:1], idx[0], s, g_out, p_out, out_valid);
    end

    // randomized traffic with random gaps
    for (int k = 0; k < 200; k++) begin
      logic [1:0] ra, rb;
      logic       rc, rv;
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      apply(ra, rb, rc, rv);
      check_all($sformatf("rand%0d", k));
      $display("rand a=%b b=%b c_in=%b in_valid=%b -> s=%b g=%b p=%b v=%b",
               ra, rb, rc, rv, s, g_out, p_out, out_valid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_2
